controller_event_gen: RTL

- Downstream consumer of the NES controller reader's 8-bit button vector {left, right, up, down, A, B, select, start}.
- Debounces each button and produces per-button level, press and release pulses.
- Optionally generates auto-repeat for direction buttons.
- Queues discrete button events in a small FIFO with a valid/ready handshake, read by game logic.

---
 rtl/controller_event_gen.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/controller_event_gen.sv
// NES controller event generator: per-button debounce, press/release pulses,
// pending-slot arbiter and a FWFT event FIFO. The release pulse port is named
// `released` because `release` is a reserved word. Auto-repeat of direction
// buttons is compiled in only when CTRL_AUTOREPEAT_EN is defined.

module controller_event_gen_lane #(
  parameter logic [15:0] DEB_CYCLES = 16'd54000
) (
  input  logic clock,
  input  logic reset,
  input  logic sample,
  output logic held,
  output logic press,
  output logic released,
  output logic rise,
  output logic fall
);
  logic [15:0] cnt;
  logic        flip;

  // rise/fall are combinational so the pending slot is set on the same edge as held
  assign flip = (sample != held) && (cnt == DEB_CYCLES - 16'd1);
  assign rise = flip & sample;
  assign fall = flip & ~sample;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      held     <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= rise;
      released <= fall;
      if (sample == held || flip) cnt <= '0;
      else                        cnt <= cnt + 16'd1;
      if (flip) held <= sample;
    end
  end
endmodule

module controller_event_gen #(
  parameter logic [15:0] DEB_CYCLES   = 16'd54000,
  parameter logic [23:0] REPEAT_DELAY = 24'd13500000,
  parameter logic [23:0] REPEAT_RATE  = 24'd2700000,
  parameter logic [7:0]  REPEAT_MASK  = 8'hF0,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] plyr_input,
  output logic [7:0] held,
  output logic [7:0] press,
  output logic [7:0] released,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_data,
  output logic       evt_overflow
);
  localparam int            AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    sample, rise, fall, edge_now;
  logic [7:0]    pend_vld, pend_rel, gnt;
  logic          wr_en, rd, can_wr;
  logic [4:0]    wr_data;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]   count, left;

`ifdef CTRL_AUTOREPEAT_EN
  logic        rpt_on, rpt_vld, rpt_gnt;
  logic [2:0]  rpt_idx, rpt_slot_idx, mrise_idx;
  logic [23:0] rpt_tmr;
  logic [7:0]  mrise;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE, REPEAT_MASK};
`endif

  always_ff @(posedge clock) begin
    if (reset) sample <= '0;
    else       sample <= plyr_input;
  end

  for (genvar g = 0; g < 8; g++) begin : g_lane
    controller_event_gen_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
      .clock    (clock),
      .reset    (reset),
      .sample   (sample[g]),
      .held     (held[g]),
      .press    (press[g]),
      .released (released[g]),
      .rise     (rise[g]),
      .fall     (fall[g])
    );
  end

  assign edge_now = rise | fall;

  // A slot granted this cycle is free to take a new edge on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_vld     <= '0;
      pend_rel     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (edge_now[i]) begin
          if (pend_vld[i] && !gnt[i]) begin
            evt_overflow <= 1'b1;
          end else begin
            pend_vld[i] <= 1'b1;
            pend_rel[i] <= fall[i];
          end
        end else if (gnt[i]) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  assign rd     = evt_valid & evt_ready;
  assign can_wr = (count != FULL) || rd;

  always_comb begin
    gnt     = '0;
    wr_en   = 1'b0;
    wr_data = '0;
`ifdef CTRL_AUTOREPEAT_EN
    rpt_gnt = 1'b0;
`endif
    if (can_wr) begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_vld[i] && !wr_en) begin
          gnt[i]  = 1'b1;
          wr_en   = 1'b1;
          wr_data = {pend_rel[i] ? 2'b10 : 2'b01, 3'(i)};
        end
      end
`ifdef CTRL_AUTOREPEAT_EN
      if (!wr_en && rpt_vld) begin
        rpt_gnt = 1'b1;
        wr_en   = 1'b1;
        wr_data = {2'b11, rpt_slot_idx};
      end
`endif
    end
  end

`ifdef CTRL_AUTOREPEAT_EN
  assign mrise = rise & REPEAT_MASK;

  always_comb begin
    mrise_idx = '0;
    for (int i = 0; i < 8; i++)
      if (mrise[i]) mrise_idx = 3'(i);
  end

  // Later assignments win: a new masked press overrides a same-cycle release
  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_on       <= 1'b0;
      rpt_vld      <= 1'b0;
      rpt_idx      <= '0;
      rpt_slot_idx <= '0;
      rpt_tmr      <= '0;
    end else begin
      if (rpt_gnt) rpt_vld <= 1'b0;
      if (rpt_on) begin
        if (rpt_tmr <= 24'd1) begin
          rpt_tmr <= REPEAT_RATE;
          if (!rpt_vld || rpt_gnt) begin
            rpt_vld      <= 1'b1;
            rpt_slot_idx <= rpt_idx;
          end
        end else begin
          rpt_tmr <= rpt_tmr - 24'd1;
        end
        if (fall[rpt_idx]) begin
          rpt_on  <= 1'b0;
          rpt_vld <= 1'b0;
        end
      end
      if (mrise != '0) begin
        rpt_on  <= 1'b1;
        rpt_idx <= mrise_idx;
        rpt_tmr <= REPEAT_DELAY;
      end
    end
  end
`endif

  // Output register shows entries present before this edge, so a write is
  // visible one cycle later and a pop never re-presents the same entry.
  assign rd_ptr_n = rd_ptr + AW'(rd);
  assign left     = count - (AW+1)'(rd);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr_n;
      count     <= left + (AW+1)'(wr_en);
      evt_valid <= (left != '0);
      evt_data  <= (left != '0) ? mem[rd_ptr_n] : '0;
    end
  end
endmodule
